// File: rtl/ip_packet_pkg.sv
// Shared constants, types and frame layout for the IPv4 transmit path.
// The frame is a fixed 36-byte Ethernet + IPv4 header + 2-byte payload image.
package ip_packet_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  VERSION_IHL    = 8'h45;
    localparam logic [7:0]  TOS            = 8'h00;
    localparam logic [15:0] IP_TOTAL_LEN   = 16'd22;
    localparam logic [15:0] IDENT          = 16'h0000;
    localparam logic [15:0] FLAGS_FRAG     = 16'h0000;
    localparam logic [7:0]  TTL            = 8'h80;
    localparam logic [7:0]  PROTOCOL       = 8'h04;

    localparam int FRAME_BYTES = 36;
    localparam int IDX_W       = 6;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
    localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(FRAME_BYTES);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [9:0]  msg;
    } tx_fields_t;

    // Byte idx of the frame, idx 0 being the first byte on the wire.
    function automatic logic [7:0] frame_byte(input tx_fields_t       f,
                                              input logic [15:0]      csum,
                                              input logic [IDX_W-1:0] idx);
        logic [FRAME_BYTES-1:0][7:0] frame;
        frame = {f.dst_mac, f.src_mac, ETHERTYPE_IPV4,
                 VERSION_IHL, TOS, IP_TOTAL_LEN, IDENT, FLAGS_FRAG,
                 TTL, PROTOCOL, csum, f.src_ip, f.dst_ip,
                 6'b000000, f.msg};
        return frame[LAST_IDX - idx];
    endfunction

endpackage

// File: rtl/ipv4_checksum_calculator.sv
// Combinational IPv4 header checksum: ones' complement of the folded sum
// of the nine header words, the checksum word itself excluded.
module ipv4_checksum_calculator (
    input  logic [7:0]  VERSION,
    input  logic [7:0]  SERVICE_TYPE,
    input  logic [15:0] LENGTH,
    input  logic [15:0] IDENTIFICATION,
    input  logic [15:0] FLAGS_AND_FRAGMENT,
    input  logic [7:0]  TTL,
    input  logic [7:0]  PROTOCOL,
    input  logic [31:0] SRC_IP_ADDRESS,
    input  logic [31:0] DST_IP_ADDRESS,
    output logic [15:0] CHECKSUM
);

    logic [19:0] sum_full;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // Nine 16-bit words fit in 20 bits; two folds always absorb every carry.
    always_comb begin
        sum_full = 20'({VERSION, SERVICE_TYPE})
                 + 20'(LENGTH)
                 + 20'(IDENTIFICATION)
                 + 20'(FLAGS_AND_FRAGMENT)
                 + 20'({TTL, PROTOCOL})
                 + 20'(SRC_IP_ADDRESS[31:16])
                 + 20'(SRC_IP_ADDRESS[15:0])
                 + 20'(DST_IP_ADDRESS[31:16])
                 + 20'(DST_IP_ADDRESS[15:0]);
        fold1    = 17'(sum_full[15:0]) + 17'(sum_full[19:16]);
        fold2    = fold1[15:0] + 16'(fold1[16]);
        CHECKSUM = ~fold2;
    end

endmodule

// File: rtl/ip_packet_tx.sv
// IPv4 frame transmitter: latches addresses and payload on START, then streams
// the 36-byte frame into the MAC one registered byte per accepted cycle.
module ip_packet_tx
    import ip_packet_pkg::*;
(
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] ACCELERATOR_IP_ADDRESS,
    input  logic [47:0] ACCELERATOR_MAC_ADDRESS,
    input  logic [31:0] RECIPIENT_IP_ADDRESS,
    input  logic [47:0] RECIPIENT_MAC_ADDRESS,
    input  logic [9:0]  RECIPIENT_MESSAGE,
    input  logic        START_IP_TXN,
    output logic        READY_FOR_SEND,
    output logic [7:0]  MAC_DATA_OUT,
    input  logic        MAC_DATA_READY,
    output logic        MAC_DATA_VALID,
    output logic        MAC_DATA_LAST,
    output logic        MAC_DATA_TUSER
);

    tx_state_e        state_q, state_d;
    tx_fields_t       fields_q, fields_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             last_q, last_d;
    logic [15:0]      checksum;

    ipv4_checksum_calculator u_checksum (
        .VERSION            (VERSION_IHL),
        .SERVICE_TYPE       (TOS),
        .LENGTH             (IP_TOTAL_LEN),
        .IDENTIFICATION     (IDENT),
        .FLAGS_AND_FRAGMENT (FLAGS_FRAG),
        .TTL                (TTL),
        .PROTOCOL           (PROTOCOL),
        .SRC_IP_ADDRESS     (fields_q.src_ip),
        .DST_IP_ADDRESS     (fields_q.dst_ip),
        .CHECKSUM           (checksum)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // idx_q reaching END_IDX means byte 35 is on the output this cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (START_IP_TXN)     state_d = SEND;
            SEND:    if (idx_q == END_IDX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        READY_FOR_SEND = (state_q == IDLE);
        MAC_DATA_VALID = (state_q == SEND);
        MAC_DATA_TUSER = 1'b0;
        MAC_DATA_OUT   = data_q;
        MAC_DATA_LAST  = last_q;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        fields_d = fields_q;
        idx_d    = idx_q;
        data_d   = 8'h00;
        last_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START_IP_TXN) begin
                    fields_d = '{dst_mac: RECIPIENT_MAC_ADDRESS,
                                 src_mac: ACCELERATOR_MAC_ADDRESS,
                                 src_ip:  ACCELERATOR_IP_ADDRESS,
                                 dst_ip:  RECIPIENT_IP_ADDRESS,
                                 msg:     RECIPIENT_MESSAGE};
                    idx_d    = '0;
                end
            end
            SEND: begin
                if (idx_q != END_IDX && MAC_DATA_READY) begin
                    data_d = frame_byte(fields_q, checksum, idx_q);
                    idx_d  = idx_q + 1'b1;
                    last_d = (idx_q == LAST_IDX);
                end
            end
            default: ;
        endcase
    end

    // NOTE: the latched fields carry no reset; they are only read in SEND,
    // which can be entered solely through the START path that loads them.
    always_ff @(posedge ACLK) begin
        fields_q <= fields_d;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            idx_q  <= '0;
            data_q <= 8'h00;
            last_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            data_q <= data_d;
            last_q <= last_d;
        end
    end

endmodule

// File: tb/tb_ip_packet_tx.sv
// Scoreboard bench for ip_packet_tx: stimulus pushes hand-computed frame bytes,
// a cycle model plus monitor pops and compares them against the MAC stream.
module tb_ip_packet_tx;

    logic        clk = 1'b0;
    logic        areset;
    logic [31:0] src_ip, dst_ip;
    logic [47:0] src_mac, dst_mac;
    logic [9:0]  msg;
    logic        start;
    logic        mac_ready;
    logic        ready_for_send;
    logic [7:0]  mac_data;
    logic        mac_valid, mac_last, mac_tuser;

    always #5 clk = ~clk;

    ip_packet_tx dut (
        .ACLK                    (clk),
        .ARESET                  (areset),
        .ACCELERATOR_IP_ADDRESS  (src_ip),
        .ACCELERATOR_MAC_ADDRESS (src_mac),
        .RECIPIENT_IP_ADDRESS    (dst_ip),
        .RECIPIENT_MAC_ADDRESS   (dst_mac),
        .RECIPIENT_MESSAGE       (msg),
        .START_IP_TXN            (start),
        .READY_FOR_SEND          (ready_for_send),
        .MAC_DATA_OUT            (mac_data),
        .MAC_DATA_READY          (mac_ready),
        .MAC_DATA_VALID          (mac_valid),
        .MAC_DATA_LAST           (mac_last),
        .MAC_DATA_TUSER          (mac_tuser)
    );

    // Hand-computed frames. A: checksum 0x1F68. B: 192.168.0.1 -> 192.168.0.199,
    // checksum 0xB8CB, message 0x2A5.
    localparam logic [287:0] FRAME_A =
        288'h32DABBADEBD5_54B00BEDABBA_0800_4500_0016_0000_0000_8004_1F68_BEEFBEEF_DEADBEEF_01FF;
    localparam logic [287:0] FRAME_B =
        288'h001122334455_A1B2C3D4E5F6_0800_4500_0016_0000_0000_8004_B8CB_C0A80001_C0A800C7_02A5;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_err = 0;

    // Bench-side cycle model of the transmitter.
    bit exp_send   = 1'b0;
    bit last_shown = 1'b0;
    bit byte_now   = 1'b0;
    int issued     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        byte_now = 1'b0;
        if (areset) begin
            exp_send   = 1'b0;
            last_shown = 1'b0;
            issued     = 0;
            exp_q.delete();
        end else if (!exp_send) begin
            if (start) begin
                exp_send   = 1'b1;
                last_shown = 1'b0;
                issued     = 0;
            end
        end else if (last_shown) begin
            exp_send   = 1'b0;
            last_shown = 1'b0;
        end else if (mac_ready) begin
            check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                cur        = exp_q.pop_front();
                byte_now   = 1'b1;
                last_shown = cur.last;
                issued++;
            end
        end
    end

    always @(negedge clk) begin
        check("tuser", 64'(mac_tuser), 64'd0);
        if (byte_now) begin
            check("byte_data", 64'(mac_data), 64'(cur.data));
            check("byte_last", 64'(mac_last), 64'(cur.last));
            check("byte_valid", 64'(mac_valid), 64'd1);
            check("byte_rfs", 64'(ready_for_send), 64'd0);
        end else if (exp_send) begin
            check("stall_data", 64'(mac_data), 64'd0);
            check("stall_last", 64'(mac_last), 64'd0);
            check("stall_valid", 64'(mac_valid), 64'd1);
            check("stall_rfs", 64'(ready_for_send), 64'd0);
        end else begin
            check("idle_data", 64'(mac_data), 64'd0);
            check("idle_last", 64'(mac_last), 64'd0);
            check("idle_valid", 64'(mac_valid), 64'd0);
            check("idle_rfs", 64'(ready_for_send), 64'd1);
        end
    end

    task automatic set_fields(input logic [47:0] dm, input logic [47:0] sm,
                              input logic [31:0] si, input logic [31:0] di,
                              input logic [9:0]  m);
        dst_mac = dm;
        src_mac = sm;
        src_ip  = si;
        dst_ip  = di;
        msg     = m;
    endtask

    function automatic int stall_for(input int idx);
        case (idx)
            4:       return 1;
            5:       return 2;
            6:       return 3;
            7:       return 4;
            20:      return 5;
            33:      return 6;
            default: return 0;
        endcase
    endfunction

    // Issue one frame. bp enables the stall table, start_at pulses START when
    // that many bytes have been sent, rst_at asserts reset at that point.
    task automatic run_frame(input logic [287:0] f, input bit bp,
                             input int start_at, input int rst_at);
        logic [287:0] fr;
        int  last_idx = -1;
        int  left     = 0;
        bit  done     = 1'b0;
        bit  pulsed   = 1'b0;
        fr = f;
        for (int i = 0; i < 36; i++)
            exp_q.push_back('{data: fr[287-8*i -: 8], last: (i == 35)});
        mac_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!exp_send) begin
                done = 1'b1;
                break;
            end
            if (rst_at >= 0 && issued == rst_at) begin
                areset = 1'b1;
                @(posedge clk); #1;
                areset = 1'b0;
                continue;
            end
            if (start_at >= 0 && issued == start_at && !pulsed) begin
                start  = 1'b1;
                pulsed = 1'b1;
                set_fields(48'h001122334455, 48'hA1B2C3D4E5F6,
                           32'hC0A80001, 32'hC0A800C7, 10'h2A5);
            end else begin
                start = 1'b0;
            end
            if (bp) begin
                if (issued != last_idx) begin
                    last_idx = issued;
                    left     = stall_for(issued);
                end
                mac_ready = (left == 0);
                if (left > 0) left--;
            end else begin
                mac_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("frame_done", 64'(done), 64'd1);
    endtask

    task automatic fields_a();
        set_fields(48'h32DABBADEBD5, 48'h54B00BEDABBA, 32'hBEEFBEEF, 32'hDEADBEEF, 10'h1FF);
    endtask

    initial begin
        areset    = 1'b1;
        start     = 1'b0;
        mac_ready = 1'b1;
        fields_a();
        repeat (3) @(posedge clk);
        #1 areset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_frame(FRAME_A, 1'b0, -1, -1);
        run_frame(FRAME_A, 1'b0, -1, -1);
        run_frame(FRAME_A, 1'b1, -1, -1);

        set_fields(48'h001122334455, 48'hA1B2C3D4E5F6, 32'hC0A80001, 32'hC0A800C7, 10'h2A5);
        run_frame(FRAME_B, 1'b0, -1, -1);

        fields_a();
        run_frame(FRAME_A, 1'b0, 15, -1);

        fields_a();
        run_frame(FRAME_A, 1'b0, -1, 11);
        run_frame(FRAME_A, 1'b0, -1, -1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/ip_packet_tx.md
IP_PACKET_TX -- requirements
Module: ip_packet_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named ACLK and ARESET.
REQ-002 Ports SHALL be as follows:
- ACLK  in  1  clock, rising edge
- ARESET  in  1  synchronous active-high reset
- ACCELERATOR_IP_ADDRESS  in  32  source IPv4 address
- ACCELERATOR_MAC_ADDRESS  in  48  source MAC address
- RECIPIENT_IP_ADDRESS  in  32  destination IPv4 address
- RECIPIENT_MAC_ADDRESS  in  48  destination MAC address
- RECIPIENT_MESSAGE  in  10  payload value
- START_IP_TXN  in  1  one-cycle start pulse
- READY_FOR_SEND  out  1  high when idle and able to accept START
- MAC_DATA_OUT  out  8  frame byte
- MAC_DATA_READY  in  1  MAC accepts bytes
- MAC_DATA_VALID  out  1  byte stream active
- MAC_DATA_LAST  out  1  final frame byte
- MAC_DATA_TUSER  out  1  tied 0

Function
REQ-003 States SHALL be IDLE and SEND; READY_FOR_SEND=1 only in IDLE.
REQ-004 IDLE with START_IP_TXN=1 at an edge -> latch all address and message inputs, byte index=0, go to SEND. START is ignored in SEND.
REQ-005 The frame SHALL be 36 bytes, transmitted in this order:
- destination MAC, MSB first (6 bytes)
- source MAC, MSB first (6 bytes)
- 0x08, 0x00
- 0x45, 0x00, 0x00, 0x16
- 0x00, 0x00, 0x00, 0x00
- 0x80, 0x04
- checksum[15:8], checksum[7:0]
- source IP, MSB first (4 bytes)
- destination IP, MSB first (4 bytes)
- {6'b0, msg[9:8]}, msg[7:0]
REQ-006 In SEND, MAC_DATA_VALID=1 from the cycle after START until the last byte.
REQ-007 At each edge in SEND with MAC_DATA_READY=1, the registered MAC_DATA_OUT SHALL load byte[index] and index SHALL increment, so data appears one cycle after READY is sampled high.
REQ-008 At each edge in SEND with MAC_DATA_READY=0, MAC_DATA_OUT SHALL load 0x00, VALID SHALL stay 1, and index SHALL hold.
REQ-009 MAC_DATA_LAST SHALL be 1 exactly while byte 35 is on MAC_DATA_OUT.
REQ-010 At the edge after byte 35 is output, the block SHALL return to IDLE with VALID=0, LAST=0, DATA=0x00 and READY_FOR_SEND=1.
REQ-011 The checksum SHALL be the IPv4 header checksum over the latched fields, computed combinationally by the sub-module:
- sum the nine 16-bit header words, excluding the checksum word
- fold carries twice into 16 bits
- take the ones' complement

Reset
REQ-012 ARESET=1 at an edge, including mid-frame, SHALL force IDLE, index=0, MAC_DATA_OUT=0x00, VALID=0, LAST=0, READY_FOR_SEND=1.
REQ-013 MAC_DATA_TUSER SHALL be 0 at all times.

Structure
REQ-014 The shared package ip_packet_pkg SHALL hold these constants:
- ETHERTYPE_IPV4=0x0800
- VERSION_IHL=0x45
- TOS=0x00
- IP_TOTAL_LEN=22
- IDENT=0x0000
- FLAGS_FRAG=0x0000
- TTL=0x80
- PROTOCOL=0x04
- FRAME_BYTES=36
- the state enum
REQ-015 The sub-module ipv4_checksum_calculator SHALL be combinational, with ports VERSION[8], SERVICE_TYPE[8], LENGTH[16], IDENTIFICATION[16], FLAGS_AND_FRAGMENT[16], TTL[8], PROTOCOL[8], SRC_IP_ADDRESS[32], DST_IP_ADDRESS[32] and CHECKSUM[16] out.

Verification
REQ-016 Checksum: src 0xBEEFBEEF, dst 0xDEADBEEF, length 22, TTL 0x80, protocol 4 -> CHECKSUM=0x1F68.
REQ-017 Full frame with READY held 1:
- stimulus: dst MAC 0x32DABBADEBD5, src MAC 0x54B00BEDABBA, msg 0x1FF
- response: bytes 32 DA BB AD EB D5 54 B0 0B ED AB BA 08 00 45 00 00 16 00 00 00 00 80 04 1F 68 BE EF BE EF DE AD BE EF 01 FF
- LAST only on 0xFF; READY_FOR_SEND=0 throughout
REQ-018 Backpressure, same frame:
- stimulus: READY low for 1,2,3,4,5,6 cycles before bytes 4,5,6,7,20,33
- response: VALID=1 and DATA=0x00 during each stall; byte sequence otherwise identical
REQ-019 Completion: one cycle after LAST -> READY_FOR_SEND=1, VALID=0; a second START then produces an identical frame.
REQ-020 Reset at byte 10 -> IDLE next edge, VALID=0, READY_FOR_SEND=1; a new START restarts at byte 0 (0x32).
REQ-021 START pulsed during SEND -> ignored; the frame completes unchanged.
